// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, header fields, VC ids, direction codes and routing helper.
// Used by both the core-side and RAM-side network interfaces.
package noc_pkg;

  localparam int unsigned FLIT_W    = 36;
  localparam int unsigned F_VALID   = 0;
  localparam int unsigned F_VC      = 1;
  localparam int unsigned F_HEAD    = 2;
  localparam int unsigned F_TAIL    = 3;
  localparam int unsigned F_DATA_LO = 4;
  localparam int unsigned F_DATA_HI = 35;

  // Bit positions inside the 32-bit head payload
  localparam int unsigned HDR_LAR_HI = 31;
  localparam int unsigned HDR_LAR_LO = 29;
  localparam int unsigned HDR_ACK    = 20;
  localparam int unsigned HDR_WE     = 18;
  localparam int unsigned HDR_SEL_HI = 17;
  localparam int unsigned HDR_SEL_LO = 14;
  localparam int unsigned HDR_ADR_HI = 13;

  localparam logic VC_REQ  = 1'b0;
  localparam logic VC_RESP = 1'b1;

  typedef logic [0:FLIT_W-1] flit_t;
  typedef logic [2:0]        dir_t;

  localparam dir_t DIR_W = 3'd0;
  localparam dir_t DIR_E = 3'd1;
  localparam dir_t DIR_S = 3'd2;
  localparam dir_t DIR_N = 3'd3;
  localparam dir_t DIR_L = 3'd4;

  typedef enum logic [2:0] {
    StIdle,
    StTxHead,
    StTxData,
    StWaitHdr,
    StWaitDat,
    StAck,
    StErr
  } ni_state_e;

  // Look-ahead route for the first hop, dimension-ordered X then Y
  function automatic dir_t lar(input logic [1:0] dst_x, input logic [1:0] dst_y,
                               input logic [1:0] my_x, input logic [1:0] my_y);
    if (dst_x > my_x)      return DIR_E;
    else if (dst_x < my_x) return DIR_W;
    else if (dst_y > my_y) return DIR_N;
    else if (dst_y < my_y) return DIR_S;
    else                   return DIR_L;
  endfunction

endpackage

// File: rtl/noc_credit_cnt.sv
// Saturating per-VC transmit credit counter; starts full at DEPTH.
// A credit return and a flit send in the same cycle cancel out.
module noc_credit_cnt #(
  parameter int unsigned DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cred_in,
  input  logic                         flit_sent,
  output logic                         ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= CW'(DEPTH);
    end else begin
      unique case ({cred_in, flit_sent})
        2'b10:   if (r_count < CW'(DEPTH)) r_count <= r_count + 1'b1;
        2'b01:   if (r_count != '0)        r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign ready = (r_count != '0);
  assign count = r_count;

endmodule

// File: rtl/ni_core.sv
// Core-side network interface: turns Wishbone loads/stores into VC0 request packets
// toward the RAM node and completes the bus cycle when the VC1 reply arrives.
module ni_core
  import noc_pkg::*;
#(
  parameter int unsigned MY_X         = 1,
  parameter int unsigned MY_Y         = 0,
  parameter int unsigned RAM_X        = 1,
  parameter int unsigned RAM_Y        = 1,
  parameter int unsigned BUFFER_DEPTH = 3,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [31:0] wb_dat_o,
  output logic [0:35] channel_out,
  input  logic [0:35] channel_in,
  input  logic [0:1]  flow_ctrl_in,
  output logic [0:1]  flow_ctrl_out
);

  localparam int unsigned CRED_W  = $clog2(BUFFER_DEPTH + 1);
  localparam logic [1:0]  L_MY_X  = 2'(MY_X);
  localparam logic [1:0]  L_MY_Y  = 2'(MY_Y);
  localparam logic [1:0]  L_RAM_X = 2'(RAM_X);
  localparam logic [1:0]  L_RAM_Y = 2'(RAM_Y);
  localparam dir_t        L_LAR   = lar(L_RAM_X, L_RAM_Y, L_MY_X, L_MY_Y);

  ni_state_e         r_state, w_state_d;
  logic              r_we;
  logic [13:0]       r_adr;
  logic [31:0]       r_wdat;
  logic [3:0]        r_sel;
  logic [31:0]       r_rdata;
  logic [31:0]       r_timer;
  logic [0:35]       r_chan_out;
  logic [0:1]        r_fc_out;

  logic              w_ready, w_cred_in, w_send_head, w_send_tail, w_timeout, w_in_wait;
  logic              w_rx_valid, w_rx_vc, w_rx_head, w_rx_tail, w_rx_ack;
  logic              w_hdr_ok, w_dat_ok;
  logic [31:0]       w_rx_data, w_head_data;
  logic [0:35]       w_flit_d;
  logic [CRED_W-1:0] w_count;
  logic              w_unused;

  assign w_rx_valid = channel_in[F_VALID];
  assign w_rx_vc    = channel_in[F_VC];
  assign w_rx_head  = channel_in[F_HEAD];
  assign w_rx_tail  = channel_in[F_TAIL];
  assign w_rx_data  = channel_in[F_DATA_LO:F_DATA_HI];
  assign w_rx_ack   = w_rx_data[HDR_ACK];
  assign w_hdr_ok   = w_rx_valid && w_rx_head && w_rx_ack;
  assign w_dat_ok   = w_rx_valid && w_rx_tail;

  // An undriven or X credit line must never corrupt the count
  assign w_cred_in  = (flow_ctrl_in[0] === 1'b1);
  assign w_in_wait  = (r_state == StWaitHdr) || (r_state == StWaitDat);
  assign w_timeout  = (TIMEOUT != 0) && (r_timer == 32'(TIMEOUT - 1));

  assign w_head_data = {L_LAR, L_RAM_X, L_RAM_Y, L_MY_X, L_MY_Y, 1'b0, 1'b0,
                        r_we, r_sel, r_adr};

  assign w_unused = ^{wb_adr_i[31:14], flow_ctrl_in[1], w_count};

  noc_credit_cnt #(
    .DEPTH (BUFFER_DEPTH)
  ) u_credit (
    .clk       (clk),
    .rst_n     (rst_n),
    .cred_in   (w_cred_in),
    .flit_sent (w_send_head | w_send_tail),
    .ready     (w_ready),
    .count     (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:    if (wb_cyc_i && wb_stb_i) w_state_d = StTxHead;
      StTxHead:  if (w_ready) w_state_d = r_we ? StTxData : StWaitHdr;
      StTxData:  if (w_ready) w_state_d = StWaitHdr;
      StWaitHdr: begin
        if (w_hdr_ok)       w_state_d = w_rx_tail ? StAck : StWaitDat;
        else if (w_timeout) w_state_d = StErr;
      end
      StWaitDat: begin
        if (w_dat_ok)       w_state_d = StAck;
        else if (w_timeout) w_state_d = StErr;
      end
      StAck:     w_state_d = StIdle;
      StErr:     w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_send_head = 1'b0;
    w_send_tail = 1'b0;
    w_flit_d    = '0;
    wb_ack_o    = 1'b0;
    wb_err_o    = 1'b0;
    wb_dat_o    = '0;
    unique case (r_state)
      StTxHead: if (w_ready) begin
        w_send_head = 1'b1;
        w_flit_d    = {1'b1, VC_REQ, 1'b1, ~r_we, w_head_data};
      end
      StTxData: if (w_ready) begin
        w_send_tail = 1'b1;
        w_flit_d    = {1'b1, VC_REQ, 1'b0, 1'b1, r_wdat};
      end
      StAck: begin
        wb_ack_o = 1'b1;
        wb_dat_o = r_rdata;
      end
      StErr:   wb_err_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we   <= 1'b0;
      r_adr  <= '0;
      r_wdat <= '0;
      r_sel  <= '0;
    end else if (r_state == StIdle && wb_cyc_i && wb_stb_i) begin
      r_we   <= wb_we_i;
      r_adr  <= wb_adr_i[13:0];
      r_wdat <= wb_dat_i;
      r_sel  <= wb_sel_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (r_state == StWaitHdr && w_hdr_ok && w_rx_tail) begin
      r_rdata <= '0;
    end else if (r_state == StWaitDat && w_dat_ok) begin
      r_rdata <= w_rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (w_in_wait && (w_state_d == StWaitHdr || w_state_d == StWaitDat)) begin
      r_timer <= r_timer + 1'b1;
    end else begin
      r_timer <= '0;
    end
  end

  // Every received flit returns its credit, whether it was used or dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chan_out <= '0;
      r_fc_out   <= '0;
    end else begin
      r_chan_out <= w_flit_d;
      r_fc_out   <= '0;
      if (w_rx_valid) r_fc_out[w_rx_vc] <= 1'b1;
    end
  end

  assign channel_out   = r_chan_out;
  assign flow_ctrl_out = r_fc_out;

endmodule

// File: tb/tb_ni_core.sv
// Scoreboard bench for ni_core: stimulus pushes expected flits, credit pulses and bus
// completions into queues; a negedge monitor pops and compares whenever the DUT shows one.
module tb_ni_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_ack_o, wb_err_o;
  logic [31:0] wb_dat_o;
  logic [0:35] channel_out, channel_in;
  logic [0:1]  flow_ctrl_in, flow_ctrl_out;

  ni_core #(
    .MY_X         (1),
    .MY_Y         (0),
    .RAM_X        (1),
    .RAM_Y        (1),
    .BUFFER_DEPTH (3),
    .TIMEOUT      (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb_cyc_i      (wb_cyc_i),
    .wb_stb_i      (wb_stb_i),
    .wb_we_i       (wb_we_i),
    .wb_adr_i      (wb_adr_i),
    .wb_dat_i      (wb_dat_i),
    .wb_sel_i      (wb_sel_i),
    .wb_ack_o      (wb_ack_o),
    .wb_err_o      (wb_err_o),
    .wb_dat_o      (wb_dat_o),
    .channel_out   (channel_out),
    .channel_in    (channel_in),
    .flow_ctrl_in  (flow_ctrl_in),
    .flow_ctrl_out (flow_ctrl_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [0:35] flit; int at; } flit_exp_t;
  typedef struct { logic ack; logic err; logic [31:0] dat; int at; } comp_exp_t;

  flit_exp_t  flit_q[$];
  comp_exp_t  comp_q[$];
  logic [0:1] fc_q[$];
  int checks = 0;
  int errors = 0;

  // Reply header from RAM(1,1) back to this node (1,0): route S, ack bit set
  localparam logic [31:0] RHDR = {3'd2, 2'd1, 2'd0, 2'd1, 2'd1, 1'b1, 20'h0};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [0:35] mk_flit(input logic vc, input logic hd, input logic tl,
                                          input logic [31:0] d);
    return {1'b1, vc, hd, tl, d};
  endfunction

  // Request head toward RAM(1,1) from (1,0): lar N=3, dst(1,1), src(1,0)
  function automatic logic [0:35] req_head(input logic we, input logic [3:0] sel,
                                           input logic [13:0] adr);
    logic [31:0] d;
    d = {3'd3, 2'd1, 2'd1, 2'd1, 2'd0, 1'b0, 1'b0, we, sel, adr};
    return {1'b1, 1'b0, 1'b1, ~we, d};
  endfunction

  task automatic push_flit(input logic [0:35] f, input int at);
    flit_exp_t e;
    e.flit = f;
    e.at   = at;
    flit_q.push_back(e);
  endtask

  task automatic push_comp(input logic ack, input logic err, input logic [31:0] d, input int at);
    comp_exp_t e;
    e.ack = ack;
    e.err = err;
    e.dat = d;
    e.at  = at;
    comp_q.push_back(e);
  endtask

  // Monitor
  flit_exp_t  m_fe;
  comp_exp_t  m_ce;
  logic [0:1] m_fc;
  always @(negedge clk) begin
    if (rst_n) begin
      if (channel_out[0] !== 1'b0) begin
        checks++;
        if (flit_q.size() == 0) begin
          errors++;
          $display("FAIL flit_unexpected got=%h at=%0d", channel_out, cyc);
        end else begin
          m_fe = flit_q.pop_front();
          if (channel_out !== m_fe.flit || (m_fe.at >= 0 && m_fe.at != cyc)) begin
            errors++;
            $display("FAIL flit got=%h@%0d exp=%h@%0d", channel_out, cyc, m_fe.flit, m_fe.at);
          end
        end
      end
      if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0) begin
        checks++;
        if (comp_q.size() == 0) begin
          errors++;
          $display("FAIL comp_unexpected ack=%b err=%b at=%0d", wb_ack_o, wb_err_o, cyc);
        end else begin
          m_ce = comp_q.pop_front();
          if (wb_ack_o !== m_ce.ack || wb_err_o !== m_ce.err || wb_dat_o !== m_ce.dat ||
              (m_ce.at >= 0 && m_ce.at != cyc)) begin
            errors++;
            $display("FAIL comp got=%b%b %h@%0d exp=%b%b %h@%0d", wb_ack_o, wb_err_o, wb_dat_o,
                     cyc, m_ce.ack, m_ce.err, m_ce.dat, m_ce.at);
          end
        end
      end
      if (flow_ctrl_out !== 2'b00) begin
        checks++;
        if (fc_q.size() == 0) begin
          errors++;
          $display("FAIL fc_unexpected got=%b at=%0d", flow_ctrl_out, cyc);
        end else begin
          m_fc = fc_q.pop_front();
          if (flow_ctrl_out !== m_fc) begin
            errors++;
            $display("FAIL fc got=%b exp=%b", flow_ctrl_out, m_fc);
          end
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output int n);
    @(negedge clk);
    n        = cyc;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_sel_i = sel;
  endtask

  task automatic send_flit(input logic vc, input logic hd, input logic tl, input logic [31:0] d);
    logic [0:1] e;
    @(negedge clk);
    channel_in = mk_flit(vc, hd, tl, d);
    e = 2'b00;
    e[vc] = 1'b1;
    fc_q.push_back(e);
    @(negedge clk);
    channel_in = '0;
  endtask

  task automatic wait_flit(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (channel_out[0] === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL %s timeout waiting for flit", name);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 60; i++) begin
      if (wb_ack_o === 1'b1 || wb_err_o === 1'b1) begin
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        return;
      end
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL %s timeout waiting for ack/err", name);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
  endtask

  task automatic fc_pulse();
    @(negedge clk);
    flow_ctrl_in = 2'b10;
    @(negedge clk);
    flow_ctrl_in = 2'b00;
  endtask

  task automatic do_read(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] rd);
    int n;
    issue(1'b0, adr, 32'h0, sel, n);
    push_flit(req_head(1'b0, sel, adr[13:0]), n + 2);
    wait_flit("read_head");
    send_flit(1'b1, 1'b1, 1'b0, RHDR);
    push_comp(1'b1, 1'b0, rd, -1);
    send_flit(1'b1, 1'b0, 1'b1, rd);
    wait_done("read_ack");
  endtask

  task automatic do_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    int n;
    issue(1'b1, adr, dat, sel, n);
    push_flit(req_head(1'b1, sel, adr[13:0]), n + 2);
    push_flit(mk_flit(1'b0, 1'b0, 1'b1, dat), n + 3);
    wait_flit("write_head");
    wait_flit("write_tail");
    push_comp(1'b1, 1'b0, 32'h0, -1);
    send_flit(1'b1, 1'b1, 1'b1, RHDR);
    wait_done("write_ack");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    channel_in = '0; flow_ctrl_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_chan", 64'(channel_out), 64'h0);
    chk("rst_ack_err", {wb_ack_o, wb_err_o}, 2'b00);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_fc", flow_ctrl_out, 2'b00);
    chk("rst_credit", dut.u_credit.count, 3);
    rst_n = 1'b1;

    // Basic read, then basic write with a single-flit reply
    do_read(32'h0000_0124, 4'hF, 32'hDEAD_BEEF);
    chk("cnt_after_read", dut.u_credit.count, 2);
    fc_pulse();
    chk("cnt_return", dut.u_credit.count, 3);
    do_write(32'h0000_0010, 32'h1234_5678, 4'h3);
    chk("cnt_after_write", dut.u_credit.count, 1);
    repeat (3) fc_pulse();
    chk("cnt_saturate", dut.u_credit.count, 3);

    // Drain credits to zero, then a held head released by one credit
    do_write(32'h0000_3FFC, 32'hA5A5_0F0F, 4'hC);
    do_read(32'hFFFF_0040, 4'h1, 32'h0BAD_F00D);
    chk("cnt_zero", dut.u_credit.count, 0);
    issue(1'b0, 32'h0000_0200, 32'h0, 4'hF, n);
    repeat (5) @(negedge clk);
    chk("stall_no_flit", channel_out[0], 1'b0);
    @(negedge clk);
    m = cyc;
    push_flit(req_head(1'b0, 4'hF, 14'h0200), m + 2);
    flow_ctrl_in = 2'b10;
    @(negedge clk);
    flow_ctrl_in = 2'b00;
    wait_flit("stall_head");
    send_flit(1'b1, 1'b1, 1'b0, RHDR);
    push_comp(1'b1, 1'b0, 32'h1111_2222, -1);
    send_flit(1'b1, 1'b0, 1'b1, 32'h1111_2222);
    wait_done("stall_ack");
    chk("cnt_zero_again", dut.u_credit.count, 0);

    // Credit return coinciding with a send leaves the count alone
    fc_pulse();
    issue(1'b0, 32'h0000_0300, 32'h0, 4'h2, n);
    push_flit(req_head(1'b0, 4'h2, 14'h0300), n + 2);
    @(negedge clk);
    flow_ctrl_in = 2'b10;
    @(negedge clk);
    flow_ctrl_in = 2'b00;
    chk("cnt_simul", dut.u_credit.count, 1);
    send_flit(1'b1, 1'b1, 1'b0, RHDR);
    push_comp(1'b1, 1'b0, 32'h0000_0001, -1);
    send_flit(1'b1, 1'b0, 1'b1, 32'h0000_0001);
    wait_done("simul_ack");

    // X on the credit line
    @(negedge clk);
    flow_ctrl_in = 2'bxx;
    @(negedge clk);
    flow_ctrl_in = 2'b00;
    chk("cnt_x_known", $isunknown(dut.u_credit.count), 1'b0);
    chk("cnt_x_value", dut.u_credit.count, 1);
    repeat (2) fc_pulse();
    chk("cnt_full", dut.u_credit.count, 3);

    // Stray flits in IDLE: credit returned, no completion
    send_flit(1'b1, 1'b0, 1'b1, 32'hCAFE_F00D);
    send_flit(1'b0, 1'b1, 1'b1, RHDR);
    repeat (3) @(negedge clk);

    // Timeout with no reply, then a late reply that must be ignored
    issue(1'b0, 32'h0000_0444, 32'h0, 4'hF, n);
    push_flit(req_head(1'b0, 4'hF, 14'h0444), n + 2);
    push_comp(1'b0, 1'b1, 32'h0, n + 18);
    wait_done("timeout_err");
    send_flit(1'b1, 1'b1, 1'b0, RHDR);
    send_flit(1'b1, 1'b0, 1'b1, 32'h7777_7777);
    repeat (3) @(negedge clk);
    fc_pulse();
    chk("cnt_after_timeout", dut.u_credit.count, 3);

    // Asynchronous reset while the write tail is on the channel
    issue(1'b1, 32'h0000_0020, 32'hFEED_FACE, 4'hF, n);
    push_flit(req_head(1'b1, 4'hF, 14'h0020), n + 2);
    wait_flit("rst_write_head");
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_tail", 64'(channel_out), 64'(mk_flit(1'b0, 1'b0, 1'b1, 32'hFEED_FACE)));
    rst_n = 1'b0;
    #1;
    chk("async_rst_chan", 64'(channel_out), 64'h0);
    chk("async_rst_outs", {wb_ack_o, wb_err_o, wb_dat_o, flow_ctrl_out}, 36'h0);
    chk("async_rst_credit", dut.u_credit.count, 3);
    @(negedge clk);
    rst_n = 1'b1;
    do_read(32'h0000_0124, 4'hF, 32'h5555_AAAA);

    repeat (5) @(negedge clk);
    chk("flit_q_empty", flit_q.size(), 0);
    chk("comp_q_empty", comp_q.size(), 0);
    chk("fc_q_empty", fc_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
